// File: rtl/breath_pkg.sv
// Shared types and sizing helpers for the breathing-LED sequencer.
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    FADE_OUT = 2'd2,
    GAP      = 2'd3
  } state_t;

  // Bits needed to hold a counter running 0..max_val (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items (at least 1).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Microsecond prescaler and PWM frame counter; both held at zero while cleared.
module pwm_timebase
  import breath_pkg::*;
#(
  parameter int CNT_US_MAX = 49,
  parameter int FRAME_MAX  = 999,
  parameter int FR_W       = cnt_w(FRAME_MAX)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  output logic            o_tick_us,
  output logic            o_frame_end,
  output logic [FR_W-1:0] o_cnt_frame
);

  localparam int US_W = cnt_w(CNT_US_MAX);

  logic [US_W-1:0] r_cnt_us;
  logic [FR_W-1:0] r_cnt_frame;
  logic            w_tick_us;
  logic            w_frame_last;

  assign w_tick_us    = (r_cnt_us == US_W'(CNT_US_MAX));
  assign w_frame_last = (r_cnt_frame == FR_W'(FRAME_MAX));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_us    <= '0;
      r_cnt_frame <= '0;
    end else if (i_clear) begin
      r_cnt_us    <= '0;
      r_cnt_frame <= '0;
    end else begin
      r_cnt_us <= w_tick_us ? '0 : r_cnt_us + 1'b1;
      if (w_tick_us)
        r_cnt_frame <= w_frame_last ? '0 : r_cnt_frame + 1'b1;
    end
  end

  assign o_tick_us   = w_tick_us;
  assign o_frame_end = w_tick_us && w_frame_last;
  assign o_cnt_frame = r_cnt_frame;

endmodule

// File: rtl/breath_seq_ctrl.sv
// Round-robin breathing sequencer: one shared fade engine drives one LED at a time,
// with a dark gap between breaths.
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int CNT_US_MAX = 49,
  parameter int FRAME_MAX  = 999,
  parameter int GAP_FRAMES = 200,
  parameter int LED_NUM    = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       start,
  input  logic                       stop,
  output logic [LED_NUM-1:0]         led_out,
  output logic [$clog2(LED_NUM)-1:0] chan_idx,
  output logic                       busy,
  output logic                       breath_done
);

  localparam int FR_W  = cnt_w(FRAME_MAX);
  localparam int GAP_W = cnt_w(GAP_FRAMES - 1);
  localparam int CH_W  = idx_w(LED_NUM);

  state_t             r_state, w_state_nxt;
  logic [FR_W-1:0]    r_level;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [CH_W-1:0]    r_chan;
  logic               r_stop_pend;
  logic [LED_NUM-1:0] r_led;
  logic               r_busy, r_done;

  logic [FR_W-1:0]    w_cnt_frame;
  logic               w_tick_us, w_frame_end, w_step, w_clear;
  logic               w_lvl_max, w_lvl_zero, w_gap_last, w_stop_eff;
  logic [LED_NUM-1:0] w_led_nxt;
  logic               w_busy_nxt, w_done_nxt;

  // Counters restart from zero both while idle and on the cycle that enters IDLE.
  assign w_clear = (r_state == IDLE) || (w_state_nxt == IDLE);

  pwm_timebase #(
    .CNT_US_MAX (CNT_US_MAX),
    .FRAME_MAX  (FRAME_MAX),
    .FR_W       (FR_W)
  ) u_timebase (
    .i_clk       (sys_clk),
    .i_rst       (sys_rst),
    .i_clear     (w_clear),
    .o_tick_us   (w_tick_us),
    .o_frame_end (w_frame_end),
    .o_cnt_frame (w_cnt_frame)
  );

  assign w_step     = w_tick_us && w_frame_end;
  assign w_lvl_max  = (r_level == FR_W'(FRAME_MAX));
  assign w_lvl_zero = (r_level == '0);
  assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_FRAMES - 1));
  assign w_stop_eff = r_stop_pend || stop;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start && !stop) w_state_nxt = FADE_IN;
      FADE_IN:  if (w_step && w_lvl_max) w_state_nxt = FADE_OUT;
      FADE_OUT: if (w_step && w_lvl_zero) w_state_nxt = w_stop_eff ? IDLE : GAP;
      GAP: begin
        if (stop)                     w_state_nxt = IDLE;
        else if (w_step && w_gap_last) w_state_nxt = FADE_IN;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_led_nxt = '0;
    if ((r_state == FADE_IN || r_state == FADE_OUT) && (w_cnt_frame < r_level))
      w_led_nxt[r_chan] = 1'b1;
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (r_state == FADE_OUT) && w_step && w_lvl_zero;
  end

  // Level, gap counter, channel pointer and deferred stop.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_level     <= '0;
      r_gap_cnt   <= '0;
      r_chan      <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        FADE_IN:  if (w_step && !w_lvl_max)  r_level <= r_level + 1'b1;
        FADE_OUT: if (w_step && !w_lvl_zero) r_level <= r_level - 1'b1;
        default:  r_level <= '0;
      endcase

      if (r_state != GAP)
        r_gap_cnt <= '0;
      else if (w_step)
        r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;

      if (r_state == GAP && w_state_nxt == FADE_IN)
        r_chan <= (r_chan == CH_W'(LED_NUM - 1)) ? '0 : r_chan + 1'b1;

      if (w_state_nxt == IDLE)
        r_stop_pend <= 1'b0;
      else if (stop && (r_state == FADE_IN || r_state == FADE_OUT))
        r_stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_led  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_led  <= w_led_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign led_out     = r_led;
  assign chan_idx    = r_chan;
  assign busy        = r_busy;
  assign breath_done = r_done;

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Scoreboard bench for breath_seq_ctrl against a cycle-position reference model.
module tb_breath_seq_ctrl;

  localparam int CNT_US_MAX = 1;
  localparam int FRAME_MAX  = 3;
  localparam int GAP_FRAMES = 2;
  localparam int LED_NUM    = 4;
  localparam int CW         = $clog2(LED_NUM);
  localparam int US_CYC     = CNT_US_MAX + 1;
  localparam int F          = US_CYC * (FRAME_MAX + 1);
  localparam int BREATH     = 2 * (FRAME_MAX + 1) * F;
  localparam int GAPC       = GAP_FRAMES * F;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               start   = 1'b0;
  logic               stop    = 1'b0;
  logic [LED_NUM-1:0] led_out;
  logic [CW-1:0]      chan_idx;
  logic               busy;
  logic               breath_done;

  breath_seq_ctrl #(
    .CNT_US_MAX (CNT_US_MAX),
    .FRAME_MAX  (FRAME_MAX),
    .GAP_FRAMES (GAP_FRAMES),
    .LED_NUM    (LED_NUM)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .stop        (stop),
    .led_out     (led_out),
    .chan_idx    (chan_idx),
    .busy        (busy),
    .breath_done (breath_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [LED_NUM-1:0] led;
    int                 chan;
    logic               busy;
    logic               done;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_phase = 0;  // 0 idle, 1 breathing, 2 gap
  int   m_t = 0;
  int   m_chan = 0;
  bit   m_pend = 1'b0;
  int   m_dones = 0;
  int   seen_dones = 0;

  // Lit state of the active LED at cycle t of a breath, from the frame/level rules.
  function automatic bit lit_at(input int t);
    int f, us, lvl;
    f   = t / F;
    us  = (t % F) / US_CYC;
    lvl = (f <= FRAME_MAX) ? f : (2 * FRAME_MAX + 1 - f);
    return us < lvl;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference model: predicts the registered outputs after each rising edge.
  always @(posedge sys_clk) begin : model
    exp_t e;
    if (sys_rst) begin
      m_phase = 0; m_t = 0; m_chan = 0; m_pend = 1'b0;
      e.led = '0; e.chan = 0; e.busy = 1'b0; e.done = 1'b0;
    end else begin
      e.led = '0;
      if (m_phase == 1 && lit_at(m_t)) e.led[m_chan] = 1'b1;
      e.done = (m_phase == 1 && m_t == BREATH - 1);
      if (e.done) begin
        done_q.push_back(m_chan);
        m_dones++;
      end
      case (m_phase)
        0: if (start && !stop) begin m_phase = 1; m_t = 0; end
        1: begin
          if (stop) m_pend = 1'b1;
          if (m_t == BREATH - 1) begin
            if (m_pend) begin m_phase = 0; m_pend = 1'b0; end
            else begin m_phase = 2; m_t = 0; end
          end else m_t++;
        end
        default: begin
          if (stop) m_phase = 0;
          else if (m_t == GAPC - 1) begin
            m_chan = (m_chan + 1) % LED_NUM; m_phase = 1; m_t = 0;
          end else m_t++;
        end
      endcase
      e.chan = m_chan;
      e.busy = (m_phase != 0);
    end
    exp_q.push_back(e);
  end

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    int   c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_out !== e.led || chan_idx !== CW'(e.chan) || busy !== e.busy || breath_done !== e.done) begin
        errors++;
        $display("FAIL cycle t=%0t: led=%b chan=%0d busy=%b done=%b, expected led=%b chan=%0d busy=%b done=%b",
                 $time, led_out, chan_idx, busy, breath_done, e.led, e.chan, e.busy, e.done);
      end
    end
    if (breath_done === 1'b1) begin
      seen_dones++;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_spurious: got pulse at chan %0d, expected none", chan_idx);
      end else begin
        c = done_q.pop_front();
        check("done_chan", chan_idx, c);
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    int n;
    n = 0;
    while (breath_done !== 1'b1 && n < max) begin tick(); n++; end
    check(nm, breath_done, 1);
  endtask

  int exp_duty[8] = '{0, 2, 4, 6, 6, 4, 2, 0};
  int duty[8];
  int exp_chans[5] = '{0, 1, 2, 3, 0};
  int gap_lit;
  int n;

  initial begin
    repeat (3) tick();
    sys_rst = 1'b0;
    repeat (100) tick();
    check("idle_busy", busy, 0);
    check("idle_led", led_out, 0);
    check("idle_chan", chan_idx, 0);
    check("idle_dones", seen_dones, 0);

    // First breath: duty per frame and done latency.
    pulse_start();
    check("busy_rise", busy, 1);
    for (int i = 0; i < 8; i++) duty[i] = 0;
    for (int t = 0; t < BREATH; t++) begin
      tick();
      duty[t / F] += int'(led_out[0]);
    end
    check("done_latency", breath_done, 1);
    for (int i = 0; i < 8; i++) check($sformatf("duty_f%0d", i), duty[i], exp_duty[i]);
    gap_lit = 0;
    for (int t = 0; t < GAPC; t++) begin
      tick();
      gap_lit += (led_out != '0) ? 1 : 0;
      if (t == GAPC - 2) check("gap_chan_hold", chan_idx, 0);
    end
    check("gap_dark", gap_lit, 0);
    check("gap_chan_adv", chan_idx, 1);

    // Remaining four breaths of the round-robin.
    for (int b = 1; b < 5; b++) begin
      wait_done(200, "rr_done");
      check($sformatf("rr_chan%0d", b), chan_idx, exp_chans[b]);
      tick();
    end
    check("rr_done_count", seen_dones, 5);

    // Stop during gap returns to idle on the next cycle.
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("gap_stop_busy", busy, 0);

    // Stop early in a breath: the breath completes, then idle.
    pulse_start();
    repeat (9) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy_hold", busy, 1);
    wait_done(100, "stop_done");
    tick();
    check("stop_idle", busy, 0);

    // start with stop while idle is ignored.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    check("start_stop_idle", busy, 0);

    // Repeated start while busy must not disturb the breath.
    pulse_start();
    repeat (20) tick();
    pulse_start();
    n = 0;
    while (chan_idx !== CW'(2) && n < 300) begin tick(); n++; end
    check("chan_before_rst", chan_idx, 2);

    // Reset asserted mid-FADE_OUT clears outputs asynchronously.
    repeat (40) tick();
    sys_rst = 1'b1;
    #1;
    check("rst_led", led_out, 0);
    check("rst_busy", busy, 0);
    check("rst_chan", chan_idx, 0);
    check("rst_done", breath_done, 0);
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    pulse_start();
    wait_done(100, "post_rst_done");
    check("post_rst_chan", chan_idx, 0);

    // Randomised start/stop traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 99) < 4);
      stop  = ($urandom_range(0, 299) < 1);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    repeat (5) tick();
    check("done_queue_empty", done_q.size(), 0);
    check("done_total", seen_dones, m_dones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
